branch_resolve_ctrl: RTL and testbench

Controller that sequences the 2-bit branch predictor against the pipeline. It queues every predicted branch at fetch and retires the oldest entry when execute resolves a branch. It drives the predictor's update inputs and, on a misprediction, squashes younger in-flight branches, asserts a multi-cycle flush and issues a one-cycle PC redirect. It sits between the fetch stage, the execute stage and the predictor.

---
 rtl/branch_resolve_ctrl.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Tracks every predicted branch from fetch in a small circular queue and
// retires the oldest entry when execute resolves a branch. It drives the
// predictor update strobe. On a misprediction it squashes all younger entries,
// raises a multi-cycle flush and issues a one-cycle PC redirect.
module branch_resolve_ctrl #(
  parameter int PC_W         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic            fetch_pred_taken,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [PC_W-1:0] fetch_target,
  output logic            fetch_ready,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  output logic            upd_branch,
  output logic            upd_taken,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            underflow,
  output logic [15:0]     mispredict_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  // Queue storage: written only, never reset; the pointers define validity
  logic            pred_mem   [DEPTH];
  logic [PC_W-1:0] pc_mem     [DEPTH];
  logic [PC_W-1:0] target_mem [DEPTH];

  state_t          state_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]       flush_cnt_reg;
  logic             upd_branch_reg;
  logic             upd_taken_reg;
  logic             flush_reg;
  logic             redirect_valid_reg;
  logic [PC_W-1:0]  redirect_pc_reg;
  logic             underflow_reg;
  logic [15:0]      mispredict_cnt_reg;

  logic             in_run;
  logic             push;
  logic             pop;
  logic             mispredict;
  logic             head_pred;
  logic [PC_W-1:0]  head_pc;
  logic [PC_W-1:0]  head_target;
  logic [PC_W-1:0]  redirect_pc_next;

  // Handshake and head-of-queue decode for the current cycle
  always_comb begin
    in_run           = (state_reg == ST_RUN);
    fetch_ready      = in_run && (count_reg < CNT_W'(DEPTH));
    push             = fetch_valid && fetch_ready;
    pop              = in_run && resolve_valid && (count_reg != '0);
    head_pred        = pred_mem[rd_ptr_reg];
    head_pc          = pc_mem[rd_ptr_reg];
    head_target      = target_mem[rd_ptr_reg];
    mispredict       = pop && (head_pred != resolve_taken);
    redirect_pc_next = resolve_taken ? head_target : (head_pc + PC_W'(4));
  end

  // Queue entry write; an entry written alongside a mispredict is orphaned
  // because the pointers are cleared in the same cycle
  always_ff @(posedge clk) begin
    if (push) begin
      pred_mem[wr_ptr_reg]   <= fetch_pred_taken;
      pc_mem[wr_ptr_reg]     <= fetch_pc;
      target_mem[wr_ptr_reg] <= fetch_target;
    end
  end

  // Control FSM, queue pointers and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_RUN;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      flush_cnt_reg      <= '0;
      upd_branch_reg     <= 1'b0;
      upd_taken_reg      <= 1'b0;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      underflow_reg      <= 1'b0;
      mispredict_cnt_reg <= '0;
    end else begin
      upd_branch_reg     <= pop;
      upd_taken_reg      <= pop && resolve_taken;
      redirect_valid_reg <= mispredict;

      case (state_reg)
        ST_RUN: begin
          if (resolve_valid && (count_reg == '0)) begin
            underflow_reg <= 1'b1;
          end
          if (mispredict) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            redirect_pc_reg <= redirect_pc_next;
            if (mispredict_cnt_reg != 16'hFFFF) begin
              mispredict_cnt_reg <= mispredict_cnt_reg + 16'd1;
            end
            flush_cnt_reg <= 3'(FLUSH_CYCLES);
            flush_reg     <= 1'b1;
            state_reg     <= ST_FLUSH;
          end else begin
            if (push) begin
              wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
              rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
              2'b10:   count_reg <= count_reg + CNT_W'(1);
              2'b01:   count_reg <= count_reg - CNT_W'(1);
              default: count_reg <= count_reg;
            endcase
          end
        end
        ST_FLUSH: begin
          // The last flush cycle is the one that sees the counter at 1
          if (flush_cnt_reg <= 3'd1) begin
            flush_cnt_reg <= '0;
            flush_reg     <= 1'b0;
            state_reg     <= ST_RUN;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg <= ST_RUN;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign upd_branch       = upd_branch_reg;
  assign upd_taken        = upd_taken_reg;
  assign flush            = flush_reg;
  assign redirect_valid   = redirect_valid_reg;
  assign redirect_pc      = redirect_pc_reg;
  assign underflow        = underflow_reg;
  assign mispredict_count = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed testbench for branch_resolve_ctrl (PC_W=32, DEPTH=4, FLUSH_CYCLES=2).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_pred_taken = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_target = '0;
  logic        fetch_ready;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        upd_branch;
  logic        upd_taken;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        underflow;
  logic [15:0] mispredict_count;

  int ntests = 0;
  int nfail  = 0;

  branch_resolve_ctrl #(.PC_W(32), .DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pred_taken(fetch_pred_taken),
    .fetch_pc(fetch_pc), .fetch_target(fetch_target), .fetch_ready(fetch_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .upd_branch(upd_branch), .upd_taken(upd_taken), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .underflow(underflow), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_valid = 1'b0; fetch_pred_taken = 1'b0; fetch_pc = '0; fetch_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic set_fetch(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    fetch_valid = 1'b1; fetch_pred_taken = pred; fetch_pc = pc; fetch_target = tgt;
  endtask

  task automatic push(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    set_fetch(pred, pc, tgt);
    cyc();
    clear_inputs();
  endtask

  task automatic resolve(input logic taken);
    resolve_valid = 1'b1; resolve_taken = taken;
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    ntests++; if (fetch_ready !== 1'b1) begin nfail++; $display("FAIL reset_fetch_ready got=%0b exp=1", fetch_ready); end
    ntests++; if ({upd_branch, upd_taken, flush, redirect_valid} !== 4'b0000) begin nfail++; $display("FAIL reset_strobes got=%b exp=0000", {upd_branch, upd_taken, flush, redirect_valid}); end
    ntests++; if (redirect_pc !== 32'h0) begin nfail++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    ntests++; if (underflow !== 1'b0) begin nfail++; $display("FAIL reset_underflow got=%0b exp=0", underflow); end
    ntests++; if (mispredict_count !== 16'h0) begin nfail++; $display("FAIL reset_mis_count got=%h exp=0", mispredict_count); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_predict_match();
    logic [2:0] preds;
    preds = 3'b101;
    do_reset();
    for (int i = 0; i < 3; i++) push(preds[i], 32'h10 + 32'(i * 4), 32'h20 + 32'(i * 16));
    for (int i = 0; i < 3; i++) begin
      resolve(preds[i]);
      ntests++; if ({upd_branch, upd_taken} !== {1'b1, preds[i]}) begin nfail++; $display("FAIL match_upd_%0d got=%b exp=%b", i, {upd_branch, upd_taken}, {1'b1, preds[i]}); end
      ntests++; if ({flush, redirect_valid} !== 2'b00) begin nfail++; $display("FAIL match_noflush_%0d got=%b exp=00", i, {flush, redirect_valid}); end
    end
    cyc();
    ntests++; if ({upd_branch, upd_taken} !== 2'b00) begin nfail++; $display("FAIL match_upd_one_cycle got=%b exp=00", {upd_branch, upd_taken}); end
    ntests++; if (mispredict_count !== 16'd0) begin nfail++; $display("FAIL match_mis_count got=%0d exp=0", mispredict_count); end
    $display("[TB] test_predict_match done");
  endtask

  task automatic test_mispredict_taken();
    do_reset();
    push(1'b0, 32'h100, 32'h200);
    resolve(1'b1);
    ntests++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h200}) begin nfail++; $display("FAIL mt_redirect got=%0b/%h exp=1/200", redirect_valid, redirect_pc); end
    ntests++; if ({upd_branch, upd_taken, flush, fetch_ready} !== 4'b1110) begin nfail++; $display("FAIL mt_n1 upd/taken/flush/ready got=%b exp=1110", {upd_branch, upd_taken, flush, fetch_ready}); end
    ntests++; if (mispredict_count !== 16'd1) begin nfail++; $display("FAIL mt_mis_count got=%0d exp=1", mispredict_count); end
    cyc();
    ntests++; if ({redirect_valid, flush, fetch_ready} !== 3'b010) begin nfail++; $display("FAIL mt_n2 redir/flush/ready got=%b exp=010", {redirect_valid, flush, fetch_ready}); end
    ntests++; if (redirect_pc !== 32'h200) begin nfail++; $display("FAIL mt_redirect_hold got=%h exp=200", redirect_pc); end
    cyc();
    ntests++; if ({flush, fetch_ready} !== 2'b01) begin nfail++; $display("FAIL mt_n3 flush/ready got=%b exp=01", {flush, fetch_ready}); end
    $display("[TB] test_mispredict_taken done");
  endtask

  task automatic test_mispredict_squash();
    do_reset();
    push(1'b1, 32'h100, 32'h200);
    push(1'b0, 32'h300, 32'h400);
    push(1'b0, 32'h500, 32'h600);
    resolve(1'b0);
    ntests++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h104}) begin nfail++; $display("FAIL sq_redirect got=%0b/%h exp=1/104", redirect_valid, redirect_pc); end
    cyc();
    cyc();
    ntests++; if ({flush, fetch_ready, underflow} !== 3'b010) begin nfail++; $display("FAIL sq_after_flush flush/ready/uf got=%b exp=010", {flush, fetch_ready, underflow}); end
    resolve(1'b0);
    ntests++; if ({underflow, upd_branch, flush} !== 3'b100) begin nfail++; $display("FAIL sq_underflow uf/upd/flush got=%b exp=100", {underflow, upd_branch, flush}); end
    cyc();
    ntests++; if (underflow !== 1'b1) begin nfail++; $display("FAIL sq_underflow_sticky got=%0b exp=1", underflow); end
    $display("[TB] test_mispredict_squash done");
  endtask

  task automatic test_full_and_wrap();
    logic [15:0] pat;
    logic [31:0] exp_pc;
    pat = 16'hB4E5;
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, 32'h40 + 32'(i * 4), 32'h80);
    ntests++; if (fetch_ready !== 1'b0) begin nfail++; $display("FAIL full_ready got=%0b exp=0", fetch_ready); end
    push(1'b1, 32'h99, 32'h99);
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0);
      ntests++; if ({upd_branch, redirect_valid} !== 2'b10) begin nfail++; $display("FAIL full_pop_%0d upd/redir got=%b exp=10", i, {upd_branch, redirect_valid}); end
    end
    resolve(1'b0);
    ntests++; if ({underflow, upd_branch} !== 2'b10) begin nfail++; $display("FAIL full_drop5 uf/upd got=%b exp=10", {underflow, upd_branch}); end

    do_reset();
    for (int i = 0; i < 3; i++) push(pat[i], 32'h1000 + 32'(i * 16), 32'h8000 + 32'(i * 256));
    for (int i = 0; i < 10; i++) begin
      set_fetch(pat[i + 3], 32'h1000 + 32'((i + 3) * 16), 32'h8000 + 32'((i + 3) * 256));
      resolve_valid = 1'b1; resolve_taken = pat[i];
      cyc();
      clear_inputs();
      ntests++; if ({upd_branch, upd_taken, redirect_valid} !== {1'b1, pat[i], 1'b0}) begin nfail++; $display("FAIL wrap_%0d upd/taken/redir got=%b exp=%b", i, {upd_branch, upd_taken, redirect_valid}, {1'b1, pat[i], 1'b0}); end
    end
    ntests++; if (fetch_ready !== 1'b1) begin nfail++; $display("FAIL wrap_count3_ready got=%0b exp=1", fetch_ready); end
    push(pat[13], 32'h1000 + 32'(13 * 16), 32'h8000 + 32'(13 * 256));
    ntests++; if (fetch_ready !== 1'b0) begin nfail++; $display("FAIL wrap_count4_ready got=%0b exp=0", fetch_ready); end
    exp_pc = pat[10] ? (32'h1000 + 32'(10 * 16) + 32'd4) : (32'h8000 + 32'(10 * 256));
    resolve(~pat[10]);
    ntests++; if ({redirect_valid, redirect_pc} !== {1'b1, exp_pc}) begin nfail++; $display("FAIL wrap_head_redirect got=%0b/%h exp=1/%h", redirect_valid, redirect_pc, exp_pc); end
    $display("[TB] test_full_and_wrap done");
  endtask

  task automatic test_mispredict_with_push();
    do_reset();
    push(1'b1, 32'h40, 32'h80);
    set_fetch(1'b0, 32'h50, 32'h90);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    cyc();
    ntests++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h44}) begin nfail++; $display("FAIL mp_redirect got=%0b/%h exp=1/44", redirect_valid, redirect_pc); end
    // Keep fetch and resolve asserted through both flush cycles
    set_fetch(1'b1, 32'h60, 32'hA0);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    cyc();
    ntests++; if ({upd_branch, underflow, flush} !== 3'b001) begin nfail++; $display("FAIL mp_flush_ignore1 upd/uf/flush got=%b exp=001", {upd_branch, underflow, flush}); end
    cyc();
    clear_inputs();
    ntests++; if ({upd_branch, underflow, flush, fetch_ready} !== 4'b0001) begin nfail++; $display("FAIL mp_flush_ignore2 upd/uf/flush/ready got=%b exp=0001", {upd_branch, underflow, flush, fetch_ready}); end
    ntests++; if (mispredict_count !== 16'd1) begin nfail++; $display("FAIL mp_mis_count got=%0d exp=1", mispredict_count); end
    resolve(1'b1);
    ntests++; if ({upd_branch, underflow} !== 2'b01) begin nfail++; $display("FAIL mp_queue_empty upd/uf got=%b exp=01", {upd_branch, underflow}); end
    $display("[TB] test_mispredict_with_push done");
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    push(1'b0, 32'h100, 32'h200);
    resolve(1'b1);
    ntests++; if ({flush, redirect_valid} !== 2'b11) begin nfail++; $display("FAIL rmf_pre flush/redir got=%b exp=11", {flush, redirect_valid}); end
    #2;
    reset = 1'b1;
    #1;
    ntests++; if ({flush, redirect_valid, upd_branch, fetch_ready} !== 4'b0001) begin nfail++; $display("FAIL rmf_async flush/redir/upd/ready got=%b exp=0001", {flush, redirect_valid, upd_branch, fetch_ready}); end
    ntests++; if ({mispredict_count, redirect_pc} !== 48'h0) begin nfail++; $display("FAIL rmf_async cnt/pc got=%h/%h exp=0/0", mispredict_count, redirect_pc); end
    reset = 1'b0;
    cyc();
    ntests++; if ({flush, fetch_ready} !== 2'b01) begin nfail++; $display("FAIL rmf_after flush/ready got=%b exp=01", {flush, fetch_ready}); end
    $display("[TB] test_reset_mid_flush done");
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.mispredict_cnt_reg = 16'hFFFE;
    #1;
    release dut.mispredict_cnt_reg;
    push(1'b0, 32'h10, 32'h20);
    resolve(1'b1);
    ntests++; if (mispredict_count !== 16'hFFFF) begin nfail++; $display("FAIL sat_reach got=%h exp=ffff", mispredict_count); end
    cyc();
    cyc();
    push(1'b1, 32'h30, 32'h40);
    resolve(1'b0);
    ntests++; if ({redirect_valid, mispredict_count} !== {1'b1, 16'hFFFF}) begin nfail++; $display("FAIL sat_hold redir/cnt got=%0b/%h exp=1/ffff", redirect_valid, mispredict_count); end
    $display("[TB] test_saturation done");
  endtask

  initial begin
    test_reset();
    test_predict_match();
    test_mispredict_taken();
    test_mispredict_squash();
    test_full_and_wrap();
    test_mispredict_with_push();
    test_reset_mid_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
